sar_conv_ctrl: RTL
==================

Name: sar_conv_ctrl

Overview:
- Sequencer for one SAR ADC channel of the column readout datapath.
- Drives the select input of the analog input MUX to choose a pixel column.
- Runs settle and sample phases on the sample/hold switch, then performs a binary search: drives a trial code to the DAC and reads the comparator each cycle.
- Returns the converted code tagged with its channel number.

Parameters:
- SEL_W, 2, channel select width; number of channels = 2**SEL_W.
- WIDTH, 8, conversion resolution in bits.
- SETTLE_CYCLES, 2, MUX settling cycles after a select change (>=1).
- SAMPLE_CYCLES, 4, cycles with sample asserted (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request one conversion; accepted only when busy=0.
- scan  in  1  request conversion of all channels 0..2**SEL_W-1 (see Optional Feature).
- ch  in  SEL_W  channel for a single conversion; latched on acceptance.
- cmp  in  1  comparator result: 1 = input >= DAC voltage.
- mux_sel  out  SEL_W  select to the analog input MUX.
- sample  out  1  sample/hold switch closed.
- dac_code  out  WIDTH  trial code to the DAC.
- busy  out  1  high in every state except IDLE.
- valid  out  1  one-cycle pulse; data and data_ch are valid.
- data  out  WIDTH  converted code, held until the next valid.
- data_ch  out  SEL_W  channel of data.

Behaviour:
- Reset values (immediate, from any state): state=IDLE; mux_sel=0, sample=0, dac_code=0, busy=0, valid=0, data=0, data_ch=0.
- States and transitions:
  - IDLE
    - Start accepted at an edge with start=1 → SETTLE; mux_sel<=ch; counter loaded.
    - scan is checked before start; scan wins if both are high.
  - SETTLE: SETTLE_CYCLES cycles, sample=0 → SAMPLE.
  - SAMPLE: SAMPLE_CYCLES cycles, sample=1 → CONVERT.
    - On exit: dac_code<=1<<(WIDTH-1); bit index i=WIDTH-1.
  - CONVERT: one bit per cycle.
    - At each edge: dac_code[i]<=cmp; if i>0, dac_code[i-1]<=1 and i<=i-1.
    - After bit 0 is resolved → DONE.
  - DONE: valid=1 for exactly this cycle; data=final code; data_ch=mux_sel.
    - Then IDLE, or SETTLE with the next channel when scanning.
- Latency: valid is high SETTLE_CYCLES+SAMPLE_CYCLES+WIDTH+1 edges after the accepting edge, i.e. 15 with defaults. dac_code holds the final code in DONE.
- start or scan while busy=1: ignored, not queued. ch changes while busy: no effect.
- mux_sel changes only on IDLE→SETTLE or DONE→SETTLE, never during SAMPLE/CONVERT.
- cmp is sampled only in CONVERT and ignored elsewhere.
- Reset mid-conversion: partial result discarded; no valid pulse.

Optional Feature:
- Macro: SAR_CONV_CTRL_SCAN_EN.
- Defined: scan=1 in IDLE converts channels 0,1,…,2**SEL_W-1 back-to-back.
  - DONE of channel k goes directly to SETTLE with mux_sel=k+1; busy stays high throughout.
  - After the last channel → IDLE.
  - One valid pulse per channel.
- Not defined: scan port present but ignored; only start/ch operate.

Decomposition:
- Package sar_pkg holds:
  - state enum typedef (IDLE, SETTLE, SAMPLE, CONVERT, DONE);
  - default constants SAR_WIDTH=8, SAR_SEL_W=2, SAR_SETTLE=2, SAR_SAMPLE=4.
- Natural sub-module: sar_approx_reg.
  - WIDTH-bit trial register plus bit index.
  - Inputs: load, step, cmp. Outputs: code, last_bit.
- The FSM and phase counter stay in sar_conv_ctrl.

Test Plan:
- Comparator model cmp=(vin_code>=dac_code), vin_code=8'hA5, start with ch=2 → mux_sel=2 during SETTLE/SAMPLE; dac_code sequence 80,C0,A0,B0,A8,A4,A6,A5; valid at edge 15 with data=8'hA5, data_ch=2.
- cmp tied 1 → data=8'hFF; cmp tied 0 → data=8'h00; exactly one valid pulse per start.
- start pulsed again at edges 3 and 10 of a conversion → ignored; one valid; mux_sel unchanged; busy low the cycle after DONE.
- reset asserted mid-CONVERT (edge 9), no clock → outputs return to reset values immediately; no valid; a new start after release converts correctly.
- scan=1 with SAR_CONV_CTRL_SCAN_EN and vin per channel {10,20,30,40} → four valid pulses 15 cycles apart with (data_ch,data)=(0,10),(1,20),(2,30),(3,40); busy continuous.
- scan=1 without the macro → no activity; busy stays 0.

Source files
------------

// File: rtl/sar_pkg.sv
// -----------------------------------------------------------------------------
// sar_pkg
// Shared definitions for the SAR ADC conversion sequencer.
//   sar_state_t : sequencer state encoding
//   SAR_*       : default values for the sequencer parameters
// -----------------------------------------------------------------------------
package sar_pkg;

   localparam int SAR_WIDTH  = 8;   // conversion resolution in bits
   localparam int SAR_SEL_W  = 2;   // channel select width
   localparam int SAR_SETTLE = 2;   // MUX settling cycles
   localparam int SAR_SAMPLE = 4;   // sample/hold closed cycles

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETTLE  = 3'd1,
      SAMPLE  = 3'd2,
      CONVERT = 3'd3,
      DONE    = 3'd4
   } sar_state_t;

endpackage

// File: rtl/sar_approx_reg.sv
// -----------------------------------------------------------------------------
// sar_approx_reg
// Successive-approximation register: holds the DAC trial code and the index of
// the bit currently under test.
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-high reset
//   load     in   start a search: code = MSB only, index = WIDTH-1
//   step     in   resolve the bit under test with cmp and move to the next bit
//   cmp      in   comparator result for the current trial code
//   code     out  current trial code (final result once bit 0 is resolved)
//   last_bit out  the bit under test is bit 0
// -----------------------------------------------------------------------------
module sar_approx_reg
   import sar_pkg::*;
#(
   parameter int WIDTH = SAR_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             cmp,
   output logic [WIDTH-1:0] code,
   output logic             last_bit
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_next;
   logic [WIDTH-1:0] code_next;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      code_next = code;
      idx_next  = idx;
      if (load) begin
         code_next            = '0;
         code_next[WIDTH-1]   = 1'b1;
         idx_next             = IDX_W'(WIDTH - 1);
      end else if (step) begin
         // Keep or drop the bit under test, then try the next lower bit.
         code_next[idx] = cmp;
         if (idx != '0) begin
            code_next[idx - IDX_W'(1)] = 1'b1;
            idx_next                   = idx - IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         code <= '0;
         idx  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         code <= code_next;
         idx  <= idx_next;
      end
   end

   assign last_bit = (idx == '0);

endmodule

// File: rtl/sar_conv_ctrl.sv
// -----------------------------------------------------------------------------
// sar_conv_ctrl
// Sequencer for one SAR ADC channel: selects a column on the analog MUX, waits
// for it to settle, closes the sample/hold switch, then runs a binary search on
// the DAC using the comparator, and returns the code tagged with its channel.
//
// Build option: define SAR_CONV_CTRL_SCAN_EN to enable the scan request, which
// converts channels 0..2**SEL_W-1 back-to-back. Without it, scan is ignored.
//
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-high reset
//   start    in   request one conversion of channel ch (accepted when idle)
//   scan     in   request conversion of all channels (optional feature)
//   ch       in   channel for a single conversion, latched on acceptance
//   cmp      in   comparator: 1 = input >= DAC voltage
//   mux_sel  out  analog input MUX select
//   sample   out  sample/hold switch closed
//   dac_code out  trial code to the DAC
//   busy     out  sequencer not idle
//   valid    out  one-cycle pulse, data/data_ch valid
//   data     out  converted code, held until the next valid
//   data_ch  out  channel of data
// -----------------------------------------------------------------------------
module sar_conv_ctrl
   import sar_pkg::*;
#(
   parameter int SEL_W         = SAR_SEL_W,
   parameter int WIDTH         = SAR_WIDTH,
   parameter int SETTLE_CYCLES = SAR_SETTLE,
   parameter int SAMPLE_CYCLES = SAR_SAMPLE
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             scan,
   input  logic [SEL_W-1:0] ch,
   input  logic             cmp,
   output logic [SEL_W-1:0] mux_sel,
   output logic             sample,
   output logic [WIDTH-1:0] dac_code,
   output logic             busy,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic [SEL_W-1:0] data_ch
);

   localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   // The phase counter counts down to zero; zero marks the last cycle of a phase.
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_CYCLES - 1);

   sar_state_t       state;
   sar_state_t       state_next;
   logic [CNT_W-1:0] cnt;
   logic             scanning;
   logic             scan_req;
   logic             last_ch;
   logic             sar_load;
   logic             sar_step;
   logic             last_bit;

`ifdef SAR_CONV_CTRL_SCAN_EN
   assign scan_req = scan;
`else
   // Scan disabled: the port stays for interface compatibility but has no effect.
   assign scan_req = scan & 1'b0;
`endif

   assign last_ch = (mux_sel == {SEL_W{1'b1}});

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (scan_req || start) state_next = SETTLE;
         SETTLE:  if (cnt == '0)         state_next = SAMPLE;
         SAMPLE:  if (cnt == '0)         state_next = CONVERT;
         CONVERT: if (last_bit)          state_next = DONE;
         DONE:    state_next = (scanning && !last_ch) ? SETTLE : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      sample   = (state == SAMPLE);
      busy     = (state != IDLE);
      valid    = (state == DONE);
      // Trial register is loaded on the last sample cycle so CONVERT starts at the MSB.
      sar_load = (state == SAMPLE) && (cnt == '0);
      sar_step = (state == CONVERT);
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mux_sel  <= '0;
         cnt      <= '0;
         scanning <= 1'b0;
         data     <= '0;
         data_ch  <= '0;
      end else begin
         case (state)
            IDLE: begin
               // scan has priority over start when both are requested.
               if (scan_req) begin
                  mux_sel  <= '0;
                  scanning <= 1'b1;
                  cnt      <= SETTLE_LOAD;
               end else if (start) begin
                  mux_sel  <= ch;
                  scanning <= 1'b0;
                  cnt      <= SETTLE_LOAD;
               end
            end
            SETTLE:  cnt <= (cnt == '0) ? SAMPLE_LOAD : cnt - CNT_W'(1);
            SAMPLE:  if (cnt != '0) cnt <= cnt - CNT_W'(1);
            CONVERT: begin
               // Capture the result on the edge that resolves bit 0 so it is
               // already stable while valid is high.
               if (last_bit) begin
                  data    <= {dac_code[WIDTH-1:1], cmp};
                  data_ch <= mux_sel;
               end
            end
            DONE: begin
               if (scanning && !last_ch) begin
                  mux_sel <= mux_sel + SEL_W'(1);
                  cnt     <= SETTLE_LOAD;
               end else begin
                  scanning <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------- SAR register
   sar_approx_reg #(
      .WIDTH (WIDTH)
   ) u_sar (
      .clk      (clk),
      .reset    (reset),
      .load     (sar_load),
      .step     (sar_step),
      .cmp      (cmp),
      .code     (dac_code),
      .last_bit (last_bit)
   );

endmodule
